// File: rtl/clb_split_sequencer.sv
// Holds one wide word and serializes its two halves onto a narrow valid/ready channel.
// IWIDTH must equal 2*OWIDTH; HI_FIRST picks which half leaves first.
module clb_split_sequencer #(
    parameter int IWIDTH   = 64,
    parameter int OWIDTH   = 32,
    parameter int HI_FIRST = 0,
    parameter int CWIDTH   = 16
) (
    input  logic              clk,
    input  logic              r,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IWIDTH-1:0] din,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OWIDTH-1:0] dout,
    output logic              out_last,
    output logic [CWIDTH-1:0] words_done
);

    typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

    state_t            state, state_nxt;
    logic [IWIDTH-1:0] hold;
    logic [CWIDTH-1:0] cnt;
    logic [OWIDTH-1:0] lo, hi, first_half, second_half;
    logic              in_fire, out_fire;

    assign lo          = hold[OWIDTH-1:0];
    assign hi          = hold[IWIDTH-1:OWIDTH];
    assign first_half  = (HI_FIRST != 0) ? hi : lo;
    assign second_half = (HI_FIRST != 0) ? lo : hi;

    assign in_fire    = in_valid & in_ready;
    assign words_done = cnt;

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        dout      = first_half;
        out_fire  = 1'b0;
        // in_ready never looks at in_valid so the producer can wait on it safely
        in_ready  = ~r & en & ((state == IDLE) | ((state == SECOND) & out_ready));
        case (state)
            IDLE: begin
                if (in_fire) state_nxt = FIRST;
            end
            FIRST: begin
                out_valid = 1'b1;
                if (out_ready & en) state_nxt = SECOND;
            end
            SECOND: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                dout      = second_half;
                if (out_ready & en) begin
                    out_fire  = 1'b1;
                    state_nxt = in_fire ? FIRST : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state <= IDLE;
            hold  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (in_fire) hold <= din;
            if (out_fire) cnt <= cnt + CWIDTH'(1);
        end
    end

endmodule

// File: tb/tb_clb_split_sequencer.sv
// Bench: two sequencers (low-first with 2-bit counter, high-first with 16-bit counter)
// share stimulus and are checked against a queue-of-halves model every cycle.
module tb_clb_split_sequencer;

    logic        clk = 1'b0;
    logic        r, en, in_valid, out_ready;
    logic [63:0] din;

    logic        ir_a, ov_a, last_a, ir_b, ov_b, last_b;
    logic [31:0] dout_a, dout_b;
    logic [1:0]  wd_a;
    logic [15:0] wd_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    clb_split_sequencer #(.IWIDTH(64), .OWIDTH(32), .HI_FIRST(0), .CWIDTH(2)) ua (
        .clk(clk), .r(r), .en(en), .in_valid(in_valid), .in_ready(ir_a), .din(din),
        .out_valid(ov_a), .out_ready(out_ready), .dout(dout_a), .out_last(last_a),
        .words_done(wd_a));

    clb_split_sequencer #(.IWIDTH(64), .OWIDTH(32), .HI_FIRST(1), .CWIDTH(16)) ub (
        .clk(clk), .r(r), .en(en), .in_valid(in_valid), .in_ready(ir_b), .din(din),
        .out_valid(ov_b), .out_ready(out_ready), .dout(dout_b), .out_last(last_b),
        .words_done(wd_b));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Model: pending halves in emission order; one word in flight at most.
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int unsigned cnt;
    bit          model_ok = 0;
    bit          m_ir;

    always @(posedge clk) begin
        if (r) begin
            qa.delete();
            qb.delete();
            cnt      = 0;
            model_ok = 1;
        end else if (en) begin
            m_ir = (qa.size() == 0) || (qa.size() == 1 && out_ready);
            if (qa.size() > 0 && out_ready) begin
                if (qa.size() == 1) cnt++;
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (in_valid && m_ir) begin
                qa.push_back(din[31:0]);
                qa.push_back(din[63:32]);
                qb.push_back(din[63:32]);
                qb.push_back(din[31:0]);
            end
        end
    end

    bit exp_ir;
    always @(negedge clk) begin
        if (model_ok) begin
            exp_ir = !r && en && ((qa.size() == 0) || (qa.size() == 1 && out_ready));
            chk("in_ready_a", 64'(ir_a), 64'(exp_ir));
            chk("in_ready_b", 64'(ir_b), 64'(exp_ir));
            chk("out_valid_a", 64'(ov_a), 64'(qa.size() > 0));
            chk("out_valid_b", 64'(ov_b), 64'(qb.size() > 0));
            chk("out_last_a", 64'(last_a), 64'(qa.size() == 1));
            chk("out_last_b", 64'(last_b), 64'(qb.size() == 1));
            if (qa.size() > 0) begin
                chk("dout_a", 64'(dout_a), 64'(qa[0]));
                chk("dout_b", 64'(dout_b), 64'(qb[0]));
            end
            chk("words_done_a", 64'(wd_a), 64'(cnt & 3));
            chk("words_done_b", 64'(wd_b), 64'(cnt & 16'hFFFF));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        r = 1; en = 1; in_valid = 1; out_ready = 1; din = 64'h0123_4567_89AB_CDEF;

        // reset held for two edges with in_valid high
        tick; tick;
        chk("rst_in_ready", 64'(ir_a), 64'd0);
        chk("rst_out_valid", 64'(ov_a), 64'd0);
        chk("rst_words_done", 64'(wd_b), 64'd0);
        chk("rst_dout", 64'(dout_a), 64'd0);
        r = 0; in_valid = 0;
        #1 chk("post_rst_in_ready", 64'(ir_a), 64'd1);

        // single word
        din = 64'hD0D0D0D0_F0F0F0F0; in_valid = 1;
        tick; in_valid = 0;
        chk("single_first_a", 64'(dout_a), 64'hF0F0F0F0);
        chk("single_first_last", 64'(last_a), 64'd0);
        chk("single_first_b", 64'(dout_b), 64'hD0D0D0D0);
        tick;
        chk("single_second_a", 64'(dout_a), 64'hD0D0D0D0);
        chk("single_second_last", 64'(last_a), 64'd1);
        chk("single_second_b", 64'(dout_b), 64'hF0F0F0F0);
        chk("single_second_last_b", 64'(last_b), 64'd1);
        tick;
        chk("single_idle_valid", 64'(ov_a), 64'd0);
        chk("single_words_a", 64'(wd_a), 64'd1);
        chk("single_words_b", 64'(wd_b), 64'd1);

        // back-to-back: halves 0..7 with no gap
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                din = {32'(i + 1), 32'(i)};
                in_valid = 1;
            end
            tick;
            if (i == 7) in_valid = 0;
            chk("b2b_valid", 64'(ov_a), 64'd1);
            chk("b2b_dout", 64'(dout_a), 64'(i));
            chk("b2b_last", 64'(last_a), 64'(i % 2));
            if (i >= 2 && i % 2 == 0) chk("b2b_words_a", 64'(wd_a), 64'((1 + i / 2) % 4));
        end
        in_valid = 0;
        tick;
        chk("b2b_end_valid", 64'(ov_a), 64'd0);
        chk("b2b_words_a", 64'(wd_a), 64'd1);
        chk("b2b_words_b", 64'(wd_b), 64'd5);

        // consumer stall in FIRST, then enable low in SECOND
        din = 64'h89ABCDEF_01234567; in_valid = 1; out_ready = 0;
        tick;
        din = 64'hFFFF0000_FFFF0000;
        #1 chk("stall_in_ready", 64'(ir_a), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("stall_dout_a", 64'(dout_a), 64'h01234567);
            chk("stall_dout_b", 64'(dout_b), 64'h89ABCDEF);
            chk("stall_last", 64'(last_a), 64'd0);
        end
        out_ready = 1;
        tick;
        en = 0;
        #1 chk("en_in_ready", 64'(ir_a), 64'd0);
        for (int k = 0; k < 2; k++) begin
            tick;
            chk("en_dout_a", 64'(dout_a), 64'h89ABCDEF);
            chk("en_last", 64'(last_a), 64'd1);
            chk("en_words_b", 64'(wd_b), 64'd5);
        end
        en = 1; in_valid = 0;
        tick;
        chk("stall_end_valid", 64'(ov_a), 64'd0);
        chk("stall_words_a", 64'(wd_a), 64'd2);
        chk("stall_words_b", 64'(wd_b), 64'd6);

        // reset in the middle of a word
        din = 64'h11112222_33334444; in_valid = 1;
        tick; in_valid = 0;
        tick;
        chk("midrst_second", 64'(dout_a), 64'h11112222);
        r = 1;
        tick; r = 0;
        #1;
        chk("midrst_valid", 64'(ov_a), 64'd0);
        chk("midrst_words_b", 64'(wd_b), 64'd0);
        chk("midrst_dout", 64'(dout_a), 64'd0);
        chk("midrst_in_ready", 64'(ir_a), 64'd1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick;
            r         = ($urandom_range(199) == 0);
            en        = ($urandom_range(9) != 0);
            in_valid  = ($urandom_range(9) < 7);
            out_ready = ($urandom_range(9) < 7);
            din       = {$urandom, $urandom};
        end
        tick; tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
